// File: rtl/fetch_buffer_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The nop encoding is also used by the decoder.
package fetch_buffer_pkg;

   localparam logic [31:0] NOP = 32'h00000013;

   typedef struct packed {
      logic        redirect;
      logic [31:0] raddr;
      logic        stall;
   } fetch_in_type;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_out_type;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } req_state_t;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_buffer_fifo.sv
// Small FIFO of {pc, instr} entries with flush taking priority over push/pop.
// The head entry is read combinationally from the registered array.
module fetch_fifo
   import fetch_buffer_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_flush,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  fetch_entry_t             i_wdata,
   output fetch_entry_t             o_rdata,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_empty,
   output logic                     o_full
);

   localparam int unsigned AW = $clog2(DEPTH);

   fetch_entry_t   r_mem [DEPTH];
   logic [AW-1:0]  r_rd_ptr;
   logic [AW-1:0]  r_wr_ptr;
   logic [AW:0]    r_count;
   logic           w_push;
   logic           w_pop;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign w_push  = i_push & ~o_full & ~i_flush;
   assign w_pop   = i_pop & ~o_empty & ~i_flush;
   assign o_count = r_count;
   assign o_rdata = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + (AW+1)'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch stage: sequential PC generation, one-outstanding imem
// handshake, redirect handling with stale-response discard, and output FIFO.
module fetch_buffer
   import fetch_buffer_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h00000000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        fetch_redirect,
   input  logic [31:0] fetch_raddr,
   input  logic        fetch_stall,
   output logic        imem_valid,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic        fetch_valid,
   output logic [31:0] fetch_pc,
   output logic [31:0] fetch_instr
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   fetch_in_type  w_in;
   fetch_out_type w_out;
   req_state_t    r_state;
   req_state_t    w_state_nxt;
   logic [31:0]   r_pc;
   logic [31:0]   r_addr;
   logic [31:0]   w_pc_nxt;
   logic          r_discard;
   logic          w_hs;
   logic          w_push;
   logic          w_pop;
   logic          w_issue;
   logic          w_empty;
   logic          w_full;
   logic [CW-1:0] w_count;
   logic [CW-1:0] w_count_nxt;
   fetch_entry_t  w_wdata;
   fetch_entry_t  w_head;

   assign w_in.redirect = fetch_redirect;
   assign w_in.raddr    = fetch_raddr;
   assign w_in.stall    = fetch_stall;

   assign w_hs    = (r_state == ST_REQ) & imem_ready;
   assign w_push  = w_hs & ~r_discard & ~w_in.redirect & ~w_full;
   assign w_pop   = ~w_empty & ~w_in.stall & ~w_in.redirect;
   assign w_wdata = '{pc: r_addr, instr: imem_rdata};

   // Occupancy after this cycle; issuing a new request is gated on it so a
   // returning word always has room.
   always_comb begin
      w_count_nxt = w_count;
      if (w_in.redirect) begin
         w_count_nxt = '0;
      end else if (w_push && !w_pop) begin
         w_count_nxt = w_count + CW'(1);
      end else if (!w_push && w_pop) begin
         w_count_nxt = w_count - CW'(1);
      end
   end

   assign w_issue = ((r_state == ST_IDLE) | w_hs) & (w_count_nxt < CW'(DEPTH));

   always_comb begin
      w_pc_nxt = r_pc;
      if (w_in.redirect) begin
         w_pc_nxt = align_word(w_in.raddr);
      end else if (w_push) begin
         w_pc_nxt = r_pc + 32'd4;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (w_issue) begin
               w_state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            if (imem_ready) begin
               w_state_nxt = w_issue ? ST_REQ : ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      imem_valid = (r_state == ST_REQ);
      imem_addr  = r_addr;
   end

   // A redirect that lands while a request waits cannot retract it; the
   // response is marked for discard and the new pc is issued afterwards.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_pc      <= RESET_PC;
         r_addr    <= RESET_PC;
         r_discard <= 1'b0;
      end else begin
         r_pc <= w_pc_nxt;
         if (w_issue) begin
            r_addr <= w_pc_nxt;
         end
         if (w_hs) begin
            r_discard <= 1'b0;
         end else if ((r_state == ST_REQ) && w_in.redirect) begin
            r_discard <= 1'b1;
         end
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clock),
      .rst_n   (reset),
      .i_flush (w_in.redirect),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata (w_wdata),
      .o_rdata (w_head),
      .o_count (w_count),
      .o_empty (w_empty),
      .o_full  (w_full)
   );

   always_comb begin
      w_out.valid = ~w_empty;
      w_out.pc    = w_empty ? 32'h0 : w_head.pc;
      w_out.instr = w_empty ? NOP : w_head.instr;
   end

   assign fetch_valid = w_out.valid;
   assign fetch_pc    = w_out.pc;
   assign fetch_instr = w_out.instr;

endmodule
